muldiv_hilo_sequencer: RTL and testbench

MULDIV_HILO_SEQUENCER -- requirements
Module: muldiv_hilo_sequencer

---
 rtl/muldiv_hilo_sequencer_pkg.sv | 23 ++
 rtl/muldiv_hilo_sequencer.sv | 159 +++++++++++++++
 tb/tb_muldiv_hilo_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_hilo_sequencer_pkg.sv
// rtl/muldiv_hilo_sequencer_pkg.sv - shared ALU control codes and multiply sequencer state encoding
//
// Purpose: ALU control code constants used by the ALU controller and the
//          HI/LO multiply sequencer, plus the sequencer FSM state encoding.
// Ports:   none (package).
package muldiv_hilo_sequencer_pkg;

    // ALU control codes that the HI/LO sequencer reacts to.
    // Every other code is ignored by the sequencer.
    localparam logic [3:0] ALU_MULT = 4'h6;
    localparam logic [3:0] ALU_MFHI = 4'hB;
    localparam logic [3:0] ALU_MFLO = 4'hC;
    localparam logic [3:0] ALU_MTHI = 4'hD;
    localparam logic [3:0] ALU_MTLO = 4'hE;

    // Multiply sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_hilo_sequencer.sv
// rtl/muldiv_hilo_sequencer.sv - sequential shift-add multiplier with HI/LO registers
//
// Purpose: Executes MULT/MULTU over DATA_WIDTH cycles (one shift-add step per
//          cycle) on operand magnitudes, fixes the sign in a closing DONE
//          cycle and writes the 2*DATA_WIDTH-bit product to HI/LO. Also
//          serves MFHI/MFLO reads and MTHI/MTLO writes while idle.
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req_valid   request present this cycle
//   alu_ctrl    operation code (MULT, MFHI, MFLO, MTHI, MTLO; others ignored)
//   is_signed   1 = signed MULT, 0 = unsigned MULTU
//   rs_data     multiplicand, or MTHI/MTLO write data
//   rt_data     multiplier
//   stall       HI/LO request cannot be taken this cycle (multiply running)
//   busy        multiply in progress (RUN or DONE)
//   done        one-cycle pulse, HI/LO update on the edge closing it
//   hilo_rdata  HI for MFHI, LO for MFLO, zero otherwise
module muldiv_hilo_sequencer
    import muldiv_hilo_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [CTRL_WIDTH-1:0] alu_ctrl,
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [DATA_WIDTH-1:0] rt_data,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hilo_rdata
);

    localparam int                        CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CTRL_WIDTH-1:0]     OP_MULT  = CTRL_WIDTH'(ALU_MULT);
    localparam logic [CTRL_WIDTH-1:0]     OP_MFHI  = CTRL_WIDTH'(ALU_MFHI);
    localparam logic [CTRL_WIDTH-1:0]     OP_MFLO  = CTRL_WIDTH'(ALU_MFLO);
    localparam logic [CTRL_WIDTH-1:0]     OP_MTHI  = CTRL_WIDTH'(ALU_MTHI);
    localparam logic [CTRL_WIDTH-1:0]     OP_MTLO  = CTRL_WIDTH'(ALU_MTLO);

    md_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q,   cnt_d;
    logic [DATA_WIDTH:0]       mcand_q, mcand_d;
    logic [2*DATA_WIDTH-1:0]   prod_q,  prod_d;
    logic                      neg_q,   neg_d;
    logic [DATA_WIDTH-1:0]     hi_q,    hi_d;
    logic [DATA_WIDTH-1:0]     lo_q,    lo_d;

    logic op_mult, op_mfhi, op_mflo, op_mthi, op_mtlo, op_hilo;

    assign op_mult = req_valid && (alu_ctrl == OP_MULT);
    assign op_mfhi = req_valid && (alu_ctrl == OP_MFHI);
    assign op_mflo = req_valid && (alu_ctrl == OP_MFLO);
    assign op_mthi = req_valid && (alu_ctrl == OP_MTHI);
    assign op_mtlo = req_valid && (alu_ctrl == OP_MTLO);
    assign op_hilo = op_mult || op_mfhi || op_mflo || op_mthi || op_mtlo;

    // Operands are extended by one bit before taking the magnitude so that
    // the most negative value (e.g. 0x80000000) yields its true magnitude.
    // For MULTU the extension bit is 0 and the magnitude is the raw value.
    logic [DATA_WIDTH:0] rs_ext, rt_ext, rs_mag, rt_mag;

    assign rs_ext = {is_signed & rs_data[DATA_WIDTH-1], rs_data};
    assign rt_ext = {is_signed & rt_data[DATA_WIDTH-1], rt_data};
    assign rs_mag = rs_ext[DATA_WIDTH] ? -rs_ext : rs_ext;
    assign rt_mag = rt_ext[DATA_WIDTH] ? -rt_ext : rt_ext;

    // One shift-add step: the multiplier sits in the low half of prod_q and
    // is consumed LSB first while the partial sum grows into the high half.
    // The extra sum bit is the carry that shifts back into the high half.
    logic [DATA_WIDTH:0]     step_sum;
    logic [2*DATA_WIDTH-1:0] result;

    assign step_sum = {1'b0, prod_q[2*DATA_WIDTH-1:DATA_WIDTH]}
                    + (prod_q[0] ? mcand_q : '0);
    assign result   = neg_q ? -prod_q : prod_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (op_mult) begin
                    mcand_d = rs_mag;
                    prod_d  = {{(DATA_WIDTH-1){1'b0}}, rt_mag};
                    neg_d   = rs_ext[DATA_WIDTH] ^ rt_ext[DATA_WIDTH];
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else if (op_mthi) begin
                    hi_d = rs_data;
                end else if (op_mtlo) begin
                    lo_d = rs_data;
                end
            end
            ST_RUN: begin
                prod_d = {step_sum, prod_q[DATA_WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                hi_d    = result[2*DATA_WIDTH-1:DATA_WIDTH];
                lo_d    = result[DATA_WIDTH-1:0];
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign stall = op_hilo && busy;

    // Reads are only presented when they are actually served; a stalled
    // read sees zero until the multiply has closed.
    always_comb begin
        hilo_rdata = '0;
        if (!busy && op_mfhi) begin
            hilo_rdata = hi_q;
        end else if (!busy && op_mflo) begin
            hilo_rdata = lo_q;
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_sequencer.sv
// tb/tb_muldiv_hilo_sequencer.sv - self-checking bench for muldiv_hilo_sequencer
module tb_muldiv_hilo_sequencer;

    localparam logic [3:0] C_MULT = 4'h6;
    localparam logic [3:0] C_MFHI = 4'hB;
    localparam logic [3:0] C_MFLO = 4'hC;
    localparam logic [3:0] C_MTHI = 4'hD;
    localparam logic [3:0] C_MTLO = 4'hE;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [3:0]  alu_ctrl;
    logic        is_signed;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hilo_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    muldiv_hilo_sequencer #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .alu_ctrl   (alu_ctrl),
        .is_signed  (is_signed),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .hilo_rdata (hilo_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1; alu_ctrl = C_MFHI;
        is_signed = 1'b0; rs_data = '0; rt_data = '0;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", stall); end
        checks++; if (hilo_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", hilo_rdata); end
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (hilo_rdata !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", hilo_rdata); end
        alu_ctrl = C_MFLO;
        #1;
        checks++; if (hilo_rdata !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", hilo_rdata); end
        req_valid = 1'b0;
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_mult(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] expv;
        int n;
        int bad_busy;
        expv = ref_product(a, b, s);
        req_valid = 1'b1; alu_ctrl = C_MULT; rs_data = a; rt_data = b; is_signed = s;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mult_accept_stall: got %0b expected 0", stall); end
        tick();
        n = 0; bad_busy = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy !== 1'b1) bad_busy++;
            req_valid = 1'($urandom_range(0, 1));
            alu_ctrl  = 4'h0;
            rs_data   = $urandom; rt_data = $urandom;
            is_signed = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        checks++; if (n != 32) begin errors++; $display("FAIL mult_latency: got %0d cycles expected 32", n); end
        checks++; if (bad_busy != 0) begin errors++; $display("FAIL mult_busy: got %0d idle cycles expected 0", bad_busy); end
        req_valid = 1'b0;
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mult_exit: got done=%0b busy=%0b expected 0 0", done, busy); end
        req_valid = 1'b1; alu_ctrl = C_MFHI;
        #1;
        checks++; if (hilo_rdata !== expv[63:32] || stall !== 1'b0) begin errors++; $display("FAIL mult_hi: got %h stall=%0b expected %h stall=0 (a=%h b=%h s=%0b)", hilo_rdata, stall, expv[63:32], a, b, s); end
        alu_ctrl = C_MFLO;
        #1;
        checks++; if (hilo_rdata !== expv[31:0] || stall !== 1'b0) begin errors++; $display("FAIL mult_lo: got %h stall=%0b expected %h stall=0 (a=%h b=%h s=%0b)", hilo_rdata, stall, expv[31:0], a, b, s); end
        req_valid = 1'b0;
        m_hi = expv[63:32]; m_lo = expv[31:0];
    endtask

    task automatic test_mtlo_run();
        logic [31:0] hv;
        logic [63:0] expv;
        int bad;
        int n;
        req_valid = 1'b1; alu_ctrl = C_MTLO; rs_data = 32'h12345678;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mtlo_stall: got %0b expected 0", stall); end
        tick();
        alu_ctrl = C_MFLO;
        #1;
        checks++; if (hilo_rdata !== 32'h12345678 || stall !== 1'b0) begin errors++; $display("FAIL mtlo_read: got %h stall=%0b expected 12345678 stall=0", hilo_rdata, stall); end
        m_lo = 32'h12345678;
        hv = $urandom;
        alu_ctrl = C_MTHI; rs_data = hv;
        tick();
        alu_ctrl = C_MFHI;
        #1;
        checks++; if (hilo_rdata !== hv) begin errors++; $display("FAIL mthi_read: got %h expected %h", hilo_rdata, hv); end
        m_hi = hv;
        alu_ctrl = C_MFLO;
        #1;
        checks++; if (hilo_rdata !== m_lo) begin errors++; $display("FAIL mthi_lo_kept: got %h expected %h", hilo_rdata, m_lo); end

        expv = ref_product(32'd1000, 32'd3, 1'b0);
        alu_ctrl = C_MULT; rs_data = 32'd1000; rt_data = 32'd3; is_signed = 1'b0;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        req_valid = 1'b1; alu_ctrl = C_MTLO; rs_data = 32'hDEADBEEF;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (stall !== 1'b1) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mtlo_run_stall: got %0d unstalled cycles expected 0", bad); end
        req_valid = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL mtlo_run_done: got done=%0b expected 1", done); end
        tick();
        req_valid = 1'b1; alu_ctrl = C_MFLO;
        #1;
        checks++; if (hilo_rdata !== expv[31:0]) begin errors++; $display("FAIL mtlo_run_lo: got %h expected %h", hilo_rdata, expv[31:0]); end
        alu_ctrl = C_MFHI;
        #1;
        checks++; if (hilo_rdata !== expv[63:32]) begin errors++; $display("FAIL mtlo_run_hi: got %h expected %h", hilo_rdata, expv[63:32]); end
        req_valid = 1'b0;
        m_hi = expv[63:32]; m_lo = expv[31:0];
    endtask

    task automatic test_stall();
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] expv;
        int n;
        int saw_done;
        a = $urandom; b = $urandom;
        expv = ref_product(a, b, 1'b1);
        req_valid = 1'b1; alu_ctrl = C_MULT; rs_data = a; rt_data = b; is_signed = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        req_valid = 1'b1; alu_ctrl = C_MFHI; rs_data = $urandom;
        #1;
        n = 0; saw_done = 0;
        while (stall === 1'b1 && n < 60) begin
            if (done === 1'b1) saw_done = 1;
            tick();
            n++;
        end
        checks++; if (n != 28) begin errors++; $display("FAIL stall_cycles: got %0d expected 28", n); end
        checks++; if (saw_done != 1) begin errors++; $display("FAIL stall_in_done: got %0d expected 1", saw_done); end
        checks++; if (hilo_rdata !== expv[63:32] || stall !== 1'b0) begin errors++; $display("FAIL stall_read_hi: got %h stall=%0b expected %h stall=0", hilo_rdata, stall, expv[63:32]); end
        alu_ctrl = C_MFLO;
        #1;
        checks++; if (hilo_rdata !== expv[31:0]) begin errors++; $display("FAIL stall_read_lo: got %h expected %h", hilo_rdata, expv[31:0]); end
        req_valid = 1'b0;
        m_hi = expv[63:32]; m_lo = expv[31:0];
    endtask

    task automatic test_ignored();
        logic [3:0] c;
        int bad;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            do c = 4'($urandom_range(0, 15));
            while (c == C_MULT || (c >= C_MFHI && c <= C_MTLO));
            req_valid = 1'($urandom_range(0, 1)); alu_ctrl = c;
            rs_data = $urandom; rt_data = $urandom; is_signed = 1'($urandom_range(0, 1));
            #1;
            if (stall !== 1'b0) bad++;
            tick();
            if (busy !== 1'b0) bad++;
        end
        req_valid = 1'b1; alu_ctrl = C_MULT; rs_data = $urandom;
        req_valid = 1'b0;
        #1;
        checks++; if (bad != 0) begin errors++; $display("FAIL ignored_effect: got %0d bad cycles expected 0", bad); end
        req_valid = 1'b1; alu_ctrl = C_MFHI;
        #1;
        checks++; if (hilo_rdata !== m_hi) begin errors++; $display("FAIL ignored_hi: got %h expected %h", hilo_rdata, m_hi); end
        alu_ctrl = C_MFLO;
        #1;
        checks++; if (hilo_rdata !== m_lo) begin errors++; $display("FAIL ignored_lo: got %h expected %h", hilo_rdata, m_lo); end
        req_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] corners [5];
        logic [31:0] a;
        logic [31:0] b;
        corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'h80000000;
        corners[3] = 32'hFFFFFFFF; corners[4] = 32'h7FFFFFFF;
        for (int i = 0; i < 8; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            test_mult(a, b, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; alu_ctrl = C_MULT; rs_data = 32'h1234; rt_data = 32'h5678; is_signed = 1'b0;
        tick();
        req_valid = 1'b0;
        repeat (10) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %0b expected 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rmid_busy: got busy=%0b done=%0b expected 0 0", busy, done); end
        req_valid = 1'b1; alu_ctrl = C_MFHI;
        #1;
        checks++; if (hilo_rdata !== 32'h0 || stall !== 1'b0) begin errors++; $display("FAIL rmid_rdata: got %h stall=%0b expected 0 stall=0", hilo_rdata, stall); end
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (hilo_rdata !== 32'h0) begin errors++; $display("FAIL rmid_hi: got %h expected 00000000", hilo_rdata); end
        alu_ctrl = C_MFLO;
        #1;
        checks++; if (hilo_rdata !== 32'h0) begin errors++; $display("FAIL rmid_lo: got %h expected 00000000", hilo_rdata); end
        req_valid = 1'b0;
        m_hi = '0; m_lo = '0;
        tick();
        test_mult(32'd7, 32'd6, 1'b1);
    endtask

    initial begin
        test_reset();
        tick();
        test_mult(32'hFFFFFFFD, 32'd5, 1'b1);
        test_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        test_mult(32'h80000000, 32'h80000000, 1'b1);
        test_mult(32'h80000000, 32'h00000003, 1'b0);
        test_mtlo_run();
        test_stall();
        test_ignored();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
